modexp_sched: RTL and testbench
===============================

Name: modexp_sched

Overview:
- Sequences the Montgomery multiplier (mon_prod) through left-to-right square-and-multiply modular exponentiation.
- Scans a latched exponent MSB-first. Issues OPXX (square) per bit, OPXM (multiply by M_bar) per set bit, and a final OPX1 to leave the Montgomery domain.
- Sits between the top-level RSA control and mon_prod. Owns mon_prod's start/op_code/mp_count inputs and watches its stop output.
- Operand memory (x_bar preloaded with R mod m, M_bar) is loaded externally before start.

Parameters:
EBITS, 1024, exponent width in bits
LENW, 11, width of exp_len (holds 0..EBITS)
ARM_CYC, 2, cycles mp_stop is ignored after each mp_start pulse

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  reset, asynchronous, active-low
start  input  1  request exponentiation; sampled only in IDLE
exponent  input  EBITS  exponent e; latched on accepted start
exp_len  input  LENW  significant exponent bits; latched; values >EBITS clamp to EBITS
mp_count_cfg  input  10  iteration count forwarded to mon_prod
mp_start  output  1  one-cycle start pulse to mon_prod
mp_op_code  output  2  0=OPXX, 1=OPXM, 2=OPX1; held stable from pulse until op completes
mp_count  output  10  registered copy of mp_count_cfg, latched on accepted start
mp_stop  input  1  mon_prod completion flag (level, high while mon_prod idle after an op)
busy  output  1  high from accepted start until done pulse (inclusive)
done  output  1  one-cycle pulse when the final OPX1 completes
op_cnt  output  12  number of mon_prod ops issued in the current run

Behaviour:
- Reset (async, rst_n=0) values: state=IDLE, mp_start=0, mp_op_code=0, mp_count=0, busy=0, done=0, op_cnt=0, bit index=0, exponent register=0.
- Reset mid-run: abandons the run immediately; mp_start drops to 0 asynchronously. mon_prod is not reset by this block; the top level must also hold mon_prod idle.
- States:
  - IDLE: on start=1, latch exponent, exp_len (clamped), mp_count_cfg; busy<=1; op_cnt<=0; idx<=len-1. Go to ISSUE with op=OPXX, or with op=OPX1 if len==0.
  - ISSUE: drive mp_start=1 for exactly one cycle with mp_op_code=op; op_cnt<=op_cnt+1; go to ARM.
  - ARM: wait ARM_CYC cycles, ignoring mp_stop. This masks the stale stop=1 left over from the previous op, since mon_prod only clears stop the cycle after it accepts start. Then go to WAIT.
  - WAIT: stay until mp_stop==1, then select the next op:
    - op=OPXX and exponent[idx]=1: next op=OPXM (same idx), go to ISSUE.
    - op=OPXX and bit=0, or op=OPXM: if idx==0, next op=OPX1; else idx<=idx-1 and next op=OPXX. Go to ISSUE.
    - op=OPX1: go to DONE.
  - DONE: done=1 for one cycle, busy<=0, go to IDLE. busy is high during the done cycle and low the next cycle.
- start while not in IDLE is ignored; no queuing. start held high after done begins a new run from IDLE one cycle after DONE.
- mp_op_code and mp_count hold their last values in IDLE.
- Total ops = exp_len + popcount(exponent[exp_len-1:0]) + 1. Maximum 2*EBITS+1 = 2049, which fits in op_cnt.
- Minimum spacing between consecutive mp_start pulses is ARM_CYC+2 cycles.
- mp_stop=1 arriving during ARM is never treated as completion. mp_stop=X before the first op is harmless because the block only samples it in WAIT.

Test Plan:
1. exponent=0xB, exp_len=4, stub mon_prod (stop latency 5) -> op sequence XX,XM,XX,XX,XM,XX,XM,X1; op_cnt=8; one done pulse; busy low the cycle after done.
2. exp_len=0, exponent=all ones -> single OPX1 issued; op_cnt=1; done after stub completes.
3. exp_len=2000 (clamped to 1024), exponent=all ones -> 2049 ops, op_cnt=2049, last op OPX1; bit index never underflows.
4. Stub that keeps stop=1 high for 1 cycle after start (real mon_prod timing) -> no premature advance; each op waits for a fresh stop.
5. rst_n pulsed low in WAIT after the 3rd op -> all outputs return to reset values immediately; a new start with exponent=0x1, exp_len=1 yields XX,XM,X1.
6. start pulsed during WAIT mid-run -> ignored; sequence and op_cnt are unchanged from the no-glitch reference run.

Source files
------------

// File: rtl/modexp_sched.sv
// Left-to-right square-and-multiply sequencer for the mon_prod Montgomery multiplier.
// Issues OPXX per exponent bit, OPXM per set bit, and a closing OPX1.
module modexp_sched #(
  parameter int EBITS   = 1024,
  parameter int LENW    = 11,
  parameter int ARM_CYC = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [EBITS-1:0] exponent,
  input  logic [LENW-1:0]  exp_len,
  input  logic [9:0]       mp_count_cfg,
  output logic             mp_start,
  output logic [1:0]       mp_op_code,
  output logic [9:0]       mp_count,
  input  logic             mp_stop,
  output logic             busy,
  output logic             done,
  output logic [11:0]      op_cnt
);

  localparam int IW = (EBITS > 1) ? $clog2(EBITS) : 1;
  localparam int AW = (ARM_CYC > 1) ? $clog2(ARM_CYC) : 1;

  localparam logic [1:0] OPXX = 2'd0;
  localparam logic [1:0] OPXM = 2'd1;
  localparam logic [1:0] OPX1 = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_ARM,
    S_WAIT,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [EBITS-1:0] exp_q, exp_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [1:0]       op_q, op_d;
  logic [9:0]       cnt_q, cnt_d;
  logic [11:0]      opn_q, opn_d;
  logic [AW-1:0]    arm_q, arm_d;
  logic [LENW-1:0]  len_c;

  assign len_c = (exp_len > LENW'(EBITS)) ? LENW'(EBITS) : exp_len;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      exp_q   <= '0;
      idx_q   <= '0;
      op_q    <= OPXX;
      cnt_q   <= '0;
      opn_q   <= '0;
      arm_q   <= '0;
    end else begin
      state_q <= state_d;
      exp_q   <= exp_d;
      idx_q   <= idx_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      opn_q   <= opn_d;
      arm_q   <= arm_d;
    end
  end

  always_comb begin
    state_d = state_q;
    exp_d   = exp_q;
    idx_d   = idx_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    opn_d   = opn_q;
    arm_d   = arm_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          exp_d   = exponent;
          cnt_d   = mp_count_cfg;
          opn_d   = '0;
          idx_d   = IW'(len_c - LENW'(1));
          op_d    = (len_c == '0) ? OPX1 : OPXX;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        opn_d   = opn_q + 12'd1;
        arm_d   = '0;
        state_d = S_ARM;
      end
      S_ARM: begin
        // stop is still high from the previous op here
        if (arm_q == AW'(ARM_CYC - 1)) state_d = S_WAIT;
        else arm_d = arm_q + AW'(1);
      end
      S_WAIT: begin
        if (mp_stop) begin
          state_d = S_ISSUE;
          unique case (1'b1)
            (op_q == OPX1): state_d = S_DONE;
            (op_q == OPXX) && exp_q[idx_q]: op_d = OPXM;
            default: begin
              if (idx_q == '0) begin
                op_d = OPX1;
              end else begin
                idx_d = idx_q - IW'(1);
                op_d  = OPXX;
              end
            end
          endcase
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign mp_start   = (state_q == S_ISSUE);
  assign done       = (state_q == S_DONE);
  assign busy       = (state_q != S_IDLE);
  assign mp_op_code = op_q;
  assign mp_count   = cnt_q;
  assign op_cnt     = opn_q;

endmodule

// File: tb/tb_modexp_sched.sv
// Scoreboarded bench for modexp_sched with a behavioural mon_prod stub.
// Expected op streams come from the square-and-multiply rule directly.
module tb_modexp_sched;

  localparam int EB = 1024;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [EB-1:0] exponent = '0;
  logic [10:0]   exp_len = '0;
  logic [9:0]    mp_count_cfg = '0;
  logic          mp_start;
  logic [1:0]    mp_op_code;
  logic [9:0]    mp_count;
  logic          mp_stop;
  logic          busy;
  logic          done;
  logic [11:0]   op_cnt;

  modexp_sched dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .exponent(exponent), .exp_len(exp_len),
    .mp_count_cfg(mp_count_cfg), .mp_start(mp_start),
    .mp_op_code(mp_op_code), .mp_count(mp_count),
    .mp_stop(mp_stop), .busy(busy), .done(done),
    .op_cnt(op_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [1:0] exp_ops[$];
  int   exp_total = 0;
  logic [9:0] exp_cfg = '0;
  int   done_seen = 0;
  int   runs = 0;
  int   starts_seen = 0;
  int   cyc = 0;
  int   last_start = -1;
  logic [1:0] cur_op = 2'd0;
  logic [1:0] want;

  // mon_prod stub: age counts cycles since the last accepted start
  int lat = 5;
  int stale = 0;
  int age;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) age <= 1000;
    else if (mp_start) age <= 0;
    else if (age < 1000) age <= age + 1;
  end
  assign mp_stop = (age < stale) || (age >= lat);

  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      if (mp_start) begin
        starts_seen++;
        checks++;
        if (exp_ops.size() == 0) begin
          errors++;
          $display("FAIL extra_op got %0d want none", mp_op_code);
        end else begin
          want = exp_ops.pop_front();
          if (mp_op_code !== want) begin
            errors++;
            $display("FAIL op_code got %0d want %0d", mp_op_code, want);
          end
        end
        checks++;
        if (age < lat) begin
          errors++;
          $display("FAIL premature_start stub_age %0d want >= %0d", age, lat);
        end
        if (last_start >= 0) begin
          checks++;
          if (cyc - last_start < 4) begin
            errors++;
            $display("FAIL spacing got %0d want >= 4", cyc - last_start);
          end
        end
        last_start = cyc;
        cur_op = mp_op_code;
      end else if (busy) begin
        checks++;
        if (mp_op_code !== cur_op) begin
          errors++;
          $display("FAIL op_stable got %0d want %0d", mp_op_code, cur_op);
        end
      end
      if (done) begin
        done_seen++;
        checks += 4;
        if (op_cnt !== 12'(exp_total)) begin
          errors++;
          $display("FAIL op_cnt got %0d want %0d", op_cnt, exp_total);
        end
        if (exp_ops.size() != 0) begin
          errors++;
          $display("FAIL ops_left got %0d want 0", exp_ops.size());
        end
        if (mp_count !== exp_cfg) begin
          errors++;
          $display("FAIL mp_count got %0d want %0d", mp_count, exp_cfg);
        end
        if (busy !== 1'b1) begin
          errors++;
          $display("FAIL busy_at_done got %0b want 1", busy);
        end
      end
    end
  end

  function automatic logic [EB-1:0] rand_exp();
    logic [EB-1:0] r;
    for (int i = 0; i < EB / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Reference: e^k by left-to-right scan of the low len bits
  task automatic build(input logic [EB-1:0] e, input int len, input logic [9:0] cfg);
    int l;
    logic [EB-1:0] m;
    l = (len > EB) ? EB : len;
    m = '0;
    for (int i = 0; i < l; i++) m[i] = 1'b1;
    exp_ops.delete();
    for (int i = l - 1; i >= 0; i--) begin
      exp_ops.push_back(2'd0);
      if (e[i]) exp_ops.push_back(2'd1);
    end
    exp_ops.push_back(2'd2);
    exp_total = l + $countones(e & m) + 1;
    exp_cfg = cfg;
  endtask

  task automatic kick(input logic [EB-1:0] e, input int len, input logic [9:0] cfg);
    build(e, len, cfg);
    @(negedge clk);
    start = 1'b1;
    exponent = e;
    exp_len = 11'(len);
    mp_count_cfg = cfg;
    @(negedge clk);
    start = 1'b0;
    exponent = rand_exp();
    exp_len = 11'($urandom_range(0, 2047));
    mp_count_cfg = 10'($urandom);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_after_start got %0b want 1", busy);
    end
  endtask

  task automatic run(input logic [EB-1:0] e, input int len, input int l_lat,
                     input int l_stale, input int glitch);
    bit hit;
    lat = l_lat;
    stale = l_stale;
    runs++;
    kick(e, len, 10'($urandom));
    hit = 1'b0;
    for (int c = 0; c < 30000; c++) begin
      if (done) begin
        hit = 1'b1;
        break;
      end
      @(negedge clk);
      start = (c == glitch);
    end
    start = 1'b0;
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL timeout got no done want done len %0d", len);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL after_done got busy %0b done %0b want 0 0", busy, done);
    end
  endtask

  task automatic chk0(input string nm, input int got);
    checks++;
    if (got != 0) begin
      errors++;
      $display("FAIL %s got %0d want 0", nm, got);
    end
  endtask

  initial begin
    logic [EB-1:0] ones;
    int s0;
    ones = '1;
    #1;
    chk0("rst_mp_start", int'(mp_start));
    chk0("rst_busy", int'(busy));
    chk0("rst_done", int'(done));
    chk0("rst_op_cnt", int'(op_cnt));
    chk0("rst_op_code", int'(mp_op_code));
    chk0("rst_mp_count", int'(mp_count));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run(EB'(32'hB), 4, 5, 0, -1);
    run(ones, 0, 5, 0, -1);
    run(ones, 2000, 3, 0, -1);
    run(EB'(32'hB5), 8, 5, 1, -1);
    run(EB'(32'h9C), 8, 4, 2, -1);
    run(EB'(32'h2D), 6, 5, 0, 10);
    run(EB'(32'h2D), 6, 5, 1, 3);

    lat = 5;
    stale = 0;
    kick(EB'(32'hFF), 8, 10'd77);
    s0 = starts_seen;
    for (int c = 0; c < 200 && starts_seen < s0 + 3; c++) @(negedge clk);
    checks++;
    if (starts_seen < s0 + 3) begin
      errors++;
      $display("FAIL reset_setup got %0d ops want 3", starts_seen - s0);
    end
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk0("midrst_mp_start", int'(mp_start));
    chk0("midrst_busy", int'(busy));
    chk0("midrst_done", int'(done));
    chk0("midrst_op_cnt", int'(op_cnt));
    chk0("midrst_op_code", int'(mp_op_code));
    chk0("midrst_mp_count", int'(mp_count));
    exp_ops.delete();
    last_start = -1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run(EB'(1), 1, 5, 0, -1);

    for (int k = 0; k < 8; k++) begin
      int l_lat;
      l_lat = $urandom_range(3, 7);
      run(rand_exp(), $urandom_range(0, 24), l_lat, $urandom_range(0, 2),
          (k % 3 == 0) ? $urandom_range(2, 30) : -1);
    end

    checks++;
    if (done_seen != runs) begin
      errors++;
      $display("FAIL done_count got %0d want %0d", done_seen, runs);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
